// File: rtl/isa_io_cycle_master.sv
`default_nettype none
// ============================================================================
// Module   : isa_io_cycle_master
// Purpose  : ISA 8-bit I/O read/write cycle initiator with IOCHRDY wait states
// Revision : 1.0 - initial release
// ============================================================================
module isa_io_cycle_master #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 8,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1,
  parameter int READY_TIMEOUT = 64
) (
  input  logic                  isa_clk,
  input  logic                  isa_reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] isa_addr,
  output logic                  isa_ior,
  output logic                  isa_iow,
  output logic [DATA_WIDTH-1:0] isa_data_out,
  output logic                  isa_data_oe,
  input  logic [DATA_WIDTH-1:0] isa_data_in,
  input  logic                  isa_iochrdy
);

  localparam int C_MAX_A = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int C_MAX_B = (HOLD_CYCLES > READY_TIMEOUT) ? HOLD_CYCLES : READY_TIMEOUT;
  localparam int C_CNT_MAX = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
  localparam int C_CNT_W = $clog2(C_CNT_MAX + 1);
  localparam logic [C_CNT_W-1:0] C_SETUP_LAST  = C_CNT_W'(SETUP_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_STROBE_LAST = C_CNT_W'(STROBE_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_HOLD_LAST   = C_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_TMO_LAST    = C_CNT_W'(READY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    STROBE   = 3'd2,
    WAIT_RDY = 3'd3,
    HOLD     = 3'd4,
    RESP     = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [C_CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]            rdy_sync_q, rdy_sync_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  tmo_q, tmo_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [ADDR_WIDTH-1:0] isa_addr_q, isa_addr_d;
  logic                  isa_ior_q, isa_ior_d;
  logic                  isa_iow_q, isa_iow_d;
  logic [DATA_WIDTH-1:0] isa_data_out_q, isa_data_out_d;
  logic                  isa_data_oe_q, isa_data_oe_d;
  logic                  rdy_s;
  logic                  strobe_active;

  assign rdy_s = rdy_sync_q[1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    tmo_d      = tmo_q;
    rdy_sync_d = {rdy_sync_q[0], isa_iochrdy};

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          tmo_d   = 1'b0;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == C_SETUP_LAST) begin
          cnt_d   = '0;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q == C_STROBE_LAST) begin
          cnt_d = '0;
          if (rdy_s) begin
            if (!write_q) rdata_d = isa_data_in;
            state_d = HOLD;
          end else begin
            state_d = WAIT_RDY;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_RDY: begin
        if (rdy_s) begin
          if (!write_q) rdata_d = isa_data_in;
          cnt_d   = '0;
          state_d = HOLD;
        end else if (cnt_q == C_TMO_LAST) begin
          if (!write_q) rdata_d = '1;
          tmo_d   = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == C_HOLD_LAST) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs follow the state one clock later, which keeps every output
    // a plain register and gives the documented cycle timing.
    strobe_active  = (state_q == STROBE) || (state_q == WAIT_RDY);
    isa_ior_d      = !(strobe_active && !write_q);
    isa_iow_d      = !(strobe_active && write_q);
    isa_data_oe_d  = write_q && (state_q == SETUP || strobe_active || state_q == HOLD);
    isa_addr_d     = (state_q == SETUP) ? addr_q : isa_addr_q;
    isa_data_out_d = (state_q == SETUP && write_q) ? wdata_q : isa_data_out_q;
    rsp_valid_d    = (state_q == RESP);
    rsp_rdata_d    = (state_q == RESP) ? rdata_q : rsp_rdata_q;
    rsp_timeout_d  = (state_q == RESP) ? tmo_q : rsp_timeout_q;
    // Ready only after a full idle cycle, so a request is never taken twice.
    req_ready_d    = (state_q == IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge isa_clk or posedge isa_reset) begin
    if (isa_reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rdy_sync_q     <= 2'b11;
      write_q        <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      tmo_q          <= 1'b0;
      req_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_timeout_q  <= 1'b0;
      isa_addr_q     <= '0;
      isa_ior_q      <= 1'b1;
      isa_iow_q      <= 1'b1;
      isa_data_out_q <= '0;
      isa_data_oe_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rdy_sync_q     <= rdy_sync_d;
      write_q        <= write_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rdata_q        <= rdata_d;
      tmo_q          <= tmo_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_timeout_q  <= rsp_timeout_d;
      isa_addr_q     <= isa_addr_d;
      isa_ior_q      <= isa_ior_d;
      isa_iow_q      <= isa_iow_d;
      isa_data_out_q <= isa_data_out_d;
      isa_data_oe_q  <= isa_data_oe_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign isa_addr     = isa_addr_q;
  assign isa_ior      = isa_ior_q;
  assign isa_iow      = isa_iow_q;
  assign isa_data_out = isa_data_out_q;
  assign isa_data_oe  = isa_data_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_isa_io_cycle_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_isa_io_cycle_master
// Purpose  : Directed self-checking bench for isa_io_cycle_master
// Revision : 1.0 - initial release
// ============================================================================
module tb_isa_io_cycle_master;

  logic       isa_clk = 1'b0;
  logic       isa_reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [9:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;
  logic [9:0] isa_addr;
  logic       isa_ior;
  logic       isa_iow;
  logic [7:0] isa_data_out;
  logic       isa_data_oe;
  logic [7:0] isa_data_in;
  logic       isa_iochrdy;

  isa_io_cycle_master #(
    .ADDR_WIDTH   (10),
    .DATA_WIDTH   (8),
    .SETUP_CYCLES (1),
    .STROBE_CYCLES(4),
    .HOLD_CYCLES  (1),
    .READY_TIMEOUT(8)
  ) u_dut (
    .isa_clk     (isa_clk),
    .isa_reset   (isa_reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .isa_addr    (isa_addr),
    .isa_ior     (isa_ior),
    .isa_iow     (isa_iow),
    .isa_data_out(isa_data_out),
    .isa_data_oe (isa_data_oe),
    .isa_data_in (isa_data_in),
    .isa_iochrdy (isa_iochrdy)
  );

  always #5 isa_clk = ~isa_clk;

  int n_checks = 0;
  int n_fail   = 0;

  int         obs_ior_low, obs_iow_low, obs_both_low, obs_first_low;
  int         obs_rsp_k, obs_rsp_cnt, obs_oe_cnt, obs_bad_addr, obs_bad_data;
  logic [7:0] obs_rdata;
  logic       obs_tmo, obs_rdy_at_rsp, obs_rdy_after;

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Returns #1 after the edge at which the handshake happened.
  task automatic wait_accept(output int waited);
    waited = 0;
    @(negedge isa_clk);
    while (!req_ready && waited < 30) begin
      @(negedge isa_clk);
      waited++;
    end
    check_value("accept_ready", req_ready, 1);
    @(posedge isa_clk);
    #1;
  endtask

  // rdy_k: IOCHRDY raised after edge T+rdy_k (negative = always high).
  // data_k: isa_data_in switches from d_early to d_late after edge T+data_k.
  task automatic run_txn(input logic wr, input logic [9:0] addr, input logic [7:0] wd,
                         input logic [7:0] d_early, input logic [7:0] d_late,
                         input int data_k, input int rdy_k);
    int waited;
    isa_iochrdy = (rdy_k < 0);
    isa_data_in = d_early;
    repeat (4) @(posedge isa_clk);
    #1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    wait_accept(waited);
    req_valid = 1'b0;
    obs_ior_low = 0; obs_iow_low = 0; obs_both_low = 0; obs_first_low = 0;
    obs_rsp_k = 0; obs_rsp_cnt = 0; obs_oe_cnt = 0; obs_bad_addr = 0; obs_bad_data = 0;
    obs_rdata = 8'h00; obs_tmo = 1'b0; obs_rdy_at_rsp = 1'b1; obs_rdy_after = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge isa_clk);
      #1;
      if (!isa_ior) obs_ior_low++;
      if (!isa_iow) obs_iow_low++;
      if (!isa_ior && !isa_iow) obs_both_low++;
      if ((!isa_ior || !isa_iow) && obs_first_low == 0) obs_first_low = k;
      if (isa_data_oe) begin
        obs_oe_cnt++;
        if (isa_data_out !== wd) obs_bad_data++;
      end
      if ((!isa_ior || !isa_iow || isa_data_oe) && isa_addr !== addr) obs_bad_addr++;
      if (obs_rsp_k != 0 && k == obs_rsp_k + 1) obs_rdy_after = req_ready;
      if (rsp_valid) begin
        obs_rsp_cnt++;
        obs_rsp_k      = k;
        obs_rdata      = rsp_rdata;
        obs_tmo        = rsp_timeout;
        obs_rdy_at_rsp = req_ready;
      end
      if (k == rdy_k) isa_iochrdy = 1'b1;
      if (k == data_k) isa_data_in = d_late;
    end
  endtask

  logic [9:0] b2b_addr [3];
  logic [7:0] b2b_data [3];

  initial begin
    int waited;
    isa_reset   = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    isa_data_in = '0;
    isa_iochrdy = 1'b1;
    #1;
    check_value("rst_ior", isa_ior, 1);
    check_value("rst_iow", isa_iow, 1);
    check_value("rst_oe", isa_data_oe, 0);
    check_value("rst_addr", isa_addr, 0);
    check_value("rst_data_out", isa_data_out, 0);
    check_value("rst_rsp_valid", rsp_valid, 0);
    check_value("rst_rsp_rdata", rsp_rdata, 0);
    check_value("rst_rsp_timeout", rsp_timeout, 0);
    check_value("rst_req_ready", req_ready, 0);
    repeat (3) @(negedge isa_clk);
    isa_reset = 1'b0;
    @(posedge isa_clk);
    #1;
    check_value("rst_ready_first_edge", req_ready, 1);

    // Write 0x3A5 <- 0x5A
    run_txn(1'b1, 10'h3A5, 8'h5A, 8'h00, 8'h00, -1, -1);
    check_value("wr_iow_low", obs_iow_low, 4);
    check_value("wr_ior_low", obs_ior_low, 0);
    check_value("wr_first_low", obs_first_low, 2);
    check_value("wr_oe_cycles", obs_oe_cnt, 6);
    check_value("wr_bad_addr", obs_bad_addr, 0);
    check_value("wr_bad_data", obs_bad_data, 0);
    check_value("wr_rsp_k", obs_rsp_k, 7);
    check_value("wr_rsp_cnt", obs_rsp_cnt, 1);
    check_value("wr_timeout", obs_tmo, 0);
    check_value("wr_rdata", obs_rdata, 8'h00);
    check_value("wr_rdy_at_rsp", obs_rdy_at_rsp, 0);
    check_value("wr_rdy_after", obs_rdy_after, 1);
    check_value("wr_addr_idle_hold", isa_addr, 10'h3A5);

    // Read 0x2F0, responder drives 0xC3
    run_txn(1'b0, 10'h2F0, 8'h00, 8'hC3, 8'hC3, -1, -1);
    check_value("rd_ior_low", obs_ior_low, 4);
    check_value("rd_iow_low", obs_iow_low, 0);
    check_value("rd_oe_cycles", obs_oe_cnt, 0);
    check_value("rd_bad_addr", obs_bad_addr, 0);
    check_value("rd_rsp_k", obs_rsp_k, 7);
    check_value("rd_rdata", obs_rdata, 8'hC3);
    check_value("rd_timeout", obs_tmo, 0);

    // Read with 3 wait cycles; data switches just before the ready sample
    run_txn(1'b0, 10'h2F1, 8'h00, 8'h11, 8'h7E, 7, 5);
    check_value("wt_ior_low", obs_ior_low, 7);
    check_value("wt_rsp_k", obs_rsp_k, 10);
    check_value("wt_rdata", obs_rdata, 8'h7E);
    check_value("wt_timeout", obs_tmo, 0);
    check_value("wt_both_low", obs_both_low, 0);

    // IOCHRDY stuck low, timeout after 8 extra cycles
    run_txn(1'b0, 10'h2F2, 8'h00, 8'h5C, 8'h5C, -1, 99);
    check_value("to_ior_low", obs_ior_low, 12);
    check_value("to_rsp_k", obs_rsp_k, 15);
    check_value("to_rdata", obs_rdata, 8'hFF);
    check_value("to_timeout", obs_tmo, 1);
    check_value("to_rsp_cnt", obs_rsp_cnt, 1);

    run_txn(1'b0, 10'h2F0, 8'h00, 8'hC3, 8'hC3, -1, -1);
    check_value("after_to_rdata", obs_rdata, 8'hC3);
    check_value("after_to_timeout", obs_tmo, 0);
    check_value("after_to_rsp_k", obs_rsp_k, 7);

    // Reset in the middle of a write strobe
    isa_iochrdy = 1'b1;
    repeat (3) @(posedge isa_clk);
    #1;
    req_write = 1'b1; req_addr = 10'h155; req_wdata = 8'hAA; req_valid = 1'b1;
    wait_accept(waited);
    req_valid = 1'b0;
    repeat (3) @(posedge isa_clk);
    #1;
    check_value("mr_iow_before", isa_iow, 0);
    #2;
    isa_reset = 1'b1;
    #1;
    check_value("mr_iow_async", isa_iow, 1);
    check_value("mr_oe_async", isa_data_oe, 0);
    check_value("mr_ready_async", req_ready, 0);
    @(negedge isa_clk);
    @(negedge isa_clk);
    isa_reset = 1'b0;
    @(posedge isa_clk);
    #1;
    check_value("mr_ready_release", req_ready, 1);
    obs_rsp_cnt = 0; obs_iow_low = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge isa_clk);
      #1;
      if (rsp_valid) obs_rsp_cnt++;
      if (!isa_iow) obs_iow_low++;
    end
    check_value("mr_no_rsp", obs_rsp_cnt, 0);
    check_value("mr_no_strobe", obs_iow_low, 0);

    // Three back-to-back writes with req_valid held high
    b2b_addr[0] = 10'h101; b2b_data[0] = 8'h11;
    b2b_addr[1] = 10'h202; b2b_data[1] = 8'h22;
    b2b_addr[2] = 10'h303; b2b_data[2] = 8'h33;
    #1;
    req_write = 1'b1; req_addr = b2b_addr[0]; req_wdata = b2b_data[0]; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_accept(waited);
      if (i > 0) check_value($sformatf("b2b_gap%0d", i), waited, 0);
      if (i < 2) begin
        req_addr  = b2b_addr[i+1];
        req_wdata = b2b_data[i+1];
      end else begin
        req_valid = 1'b0;
      end
      for (int k = 1; k <= 8; k++) begin
        @(posedge isa_clk);
        #1;
        if (k == 1) check_value($sformatf("b2b_ready_busy%0d", i), req_ready, 0);
        if (k == 3) begin
          check_value($sformatf("b2b_iow%0d", i), isa_iow, 0);
          check_value($sformatf("b2b_addr%0d", i), isa_addr, b2b_addr[i]);
          check_value($sformatf("b2b_data%0d", i), isa_data_out, b2b_data[i]);
        end
        if (k == 7) check_value($sformatf("b2b_rsp%0d", i), rsp_valid, 1);
        if (k == 8) check_value($sformatf("b2b_ready%0d", i), req_ready, 1);
      end
    end
    repeat (3) @(posedge isa_clk);
    #1;
    check_value("b2b_idle_ready", req_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
